// File: rtl/ps2_colour_ctrl.sv
// PS/2 keyboard receiver that turns A/S/D/F make codes into one-hot colour
// events with a valid/ack handshake, and tracks which colour keys are held.
//
// rx state  | meaning
// RX_IDLE   | waiting for a start bit (data low on a falling PS/2 clock)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | checking odd parity over data plus parity bit
// RX_STOP   | checking stop bit; emits byte_strobe or frame_err
//
// dec state     | meaning
// DEC_NORMAL    | expecting a make code or a prefix
// DEC_BREAK     | last byte was F0; next byte is a key release
// DEC_EXT       | last byte was E0; extended code follows
// DEC_EXT_BREAK | saw E0 F0; next byte is an extended release
module ps2_colour_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLOCK,
  input  logic       PS2_DATA,
  input  logic       colour_ack,
  output logic [3:0] colour,
  output logic       colour_valid,
  output logic [3:0] key_held,
  output logic       frame_err,
  output logic       overrun
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {DEC_NORMAL, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_e;

  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;
  logic          fall;
  rx_state_e     rx_state_q, rx_state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_strobe_q, byte_strobe_d;
  logic          frame_err_q, frame_err_d;

  dec_state_e    dec_state_q, dec_state_d;
  logic [3:0]    colour_q, colour_d;
  logic [3:0]    held_q, held_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic [3:0]    key;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q    <= 1'b1;
      clk_sync_q    <= 1'b1;
      clk_prev_q    <= 1'b1;
      dat_meta_q    <= 1'b1;
      dat_sync_q    <= 1'b1;
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_ok_q      <= 1'b0;
      to_cnt_q      <= '0;
      byte_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
      dec_state_q   <= DEC_NORMAL;
      colour_q      <= '0;
      held_q        <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      clk_meta_q    <= PS2_CLOCK;
      clk_sync_q    <= clk_meta_q;
      clk_prev_q    <= clk_sync_q;
      dat_meta_q    <= PS2_DATA;
      dat_sync_q    <= dat_meta_q;
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_ok_q      <= par_ok_d;
      to_cnt_q      <= to_cnt_d;
      byte_strobe_q <= byte_strobe_d;
      frame_err_q   <= frame_err_d;
      dec_state_q   <= dec_state_d;
      colour_q      <= colour_d;
      held_q        <= held_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // The timeout counter only runs between falling edges of a partial frame.
  always_comb begin
    rx_state_d    = rx_state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_ok_d      = par_ok_q;
    to_cnt_d      = '0;
    byte_strobe_d = 1'b0;
    frame_err_d   = 1'b0;
    if (fall) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!dat_sync_q) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d   = ^{shift_q, dat_sync_q};
          rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          if (dat_sync_q && par_ok_q) byte_strobe_d = 1'b1;
          else                        frame_err_d   = 1'b1;
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end else if (rx_state_q != RX_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        frame_err_d = 1'b1;
        rx_state_d  = RX_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (shift_q)
      8'h1C:   key = 4'b0001;
      8'h1B:   key = 4'b0010;
      8'h23:   key = 4'b0100;
      8'h2B:   key = 4'b1000;
      default: key = 4'b0000;
    endcase
  end

  // An ack in the same cycle as a new make frees the slot for that make.
  always_comb begin
    dec_state_d = dec_state_q;
    colour_d    = colour_q;
    valid_d     = valid_q;
    held_d      = held_q;
    overrun_d   = 1'b0;
    if (valid_q && colour_ack) begin
      valid_d  = 1'b0;
      colour_d = '0;
    end
    if (byte_strobe_q) begin
      case (dec_state_q)
        DEC_NORMAL: begin
          if (shift_q == 8'hF0) begin
            dec_state_d = DEC_BREAK;
          end else if (shift_q == 8'hE0) begin
            dec_state_d = DEC_EXT;
          end else if ((|key) && !(|(held_q & key))) begin
            held_d = held_q | key;
            if (!valid_d) begin
              colour_d = key;
              valid_d  = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        DEC_BREAK: begin
          held_d      = held_q & ~key;
          dec_state_d = DEC_NORMAL;
        end
        DEC_EXT: dec_state_d = (shift_q == 8'hF0) ? DEC_EXT_BREAK : DEC_NORMAL;
        default: dec_state_d = DEC_NORMAL;
      endcase
    end
  end

  assign colour       = colour_q;
  assign colour_valid = valid_q;
  assign key_held     = held_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule
